// File: rtl/apb4_rtc_tick.sv
// APB4 RTC tick generator: divides pclk or a synchronized ext clock.
// Optional `RTC_TICK_FILTER_EN adds a 3-sample majority filter on ext_clk_i.
module apb4_rtc_tick #(
    parameter int RTC_DIV_WIDTH = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        ext_clk_i,
    output logic        rtc_clk_o,
    output logic        tick_irq_o
);
    localparam int W = RTC_DIV_WIDTH;

    logic         wr, rd, clr;
    logic [3:0]   idx;
    logic         en_q, en_d, src_q, src_d, tie_q, tie_d;
    logic [W-1:0] div_q, div_d, div_act_q, div_act_d, cnt_q, cnt_d;
    logic         rtc_q, rtc_d, rise_q, rise_d, tickf_q, tickf_d;
    logic         sync1_q, sync2_q, edge_q, lvl, ext_ev, ev;
    logic         unused_ok;
`ifdef RTC_TICK_FILTER_EN
    logic [2:0]   filt_q;
`endif

    assign idx       = paddr[5:2];
    assign wr        = psel & penable & pwrite;
    assign rd        = psel & penable & ~pwrite;
    assign clr       = wr & (idx == 4'd3) & pwdata[0];
    assign pready    = 1'b1;
    assign pslverr   = 1'b0;
    assign rtc_clk_o = rtc_q;
    assign tick_irq_o = tickf_q & tie_q;
    assign unused_ok = ^{paddr[31:6], paddr[1:0], pwdata};

`ifdef RTC_TICK_FILTER_EN
    // Majority of the last three synchronized samples suppresses short glitches.
    always_comb begin
        lvl = (filt_q[0] & filt_q[1]) | (filt_q[1] & filt_q[2])
            | (filt_q[0] & filt_q[2]);
    end
`else
    // Without the filter the synchronizer output feeds edge detection directly.
    always_comb begin
        lvl = sync2_q;
    end
`endif

    // Source event select: every cycle for pclk, rising edges for ext.
    always_comb begin
        ext_ev = lvl & ~edge_q;
        ev     = src_q ? ext_ev : 1'b1;
    end

    // Register writes; CTRL and DIV hold unless addressed.
    always_comb begin
        en_d  = en_q;
        src_d = src_q;
        tie_d = tie_q;
        div_d = div_q;
        if (wr && idx == 4'd0) begin
            en_d  = pwdata[0];
            src_d = pwdata[1];
            tie_d = pwdata[2];
        end
        if (wr && idx == 4'd1) begin
            div_d = pwdata[W-1:0];
        end
    end

    // Prescaler: DIV is picked up only at terminal count or while disabled.
    always_comb begin
        cnt_d     = cnt_q;
        rtc_d     = rtc_q;
        div_act_d = div_act_q;
        if (!en_q) begin
            cnt_d     = '0;
            rtc_d     = 1'b0;
            div_act_d = div_q;
        end else if (ev) begin
            if (cnt_q == div_act_q) begin
                cnt_d     = '0;
                rtc_d     = ~rtc_q;
                div_act_d = div_q;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
        rise_d  = rtc_d & ~rtc_q;
        tickf_d = rise_q | (tickf_q & ~clr);
    end

    // Read mux, zero outside the read access phase.
    always_comb begin
        prdata = '0;
        if (rd) begin
            case (idx)
                4'd0:    prdata = {29'd0, tie_q, src_q, en_q};
                4'd1:    prdata = 32'(div_q);
                4'd2:    prdata = 32'(cnt_q);
                4'd3:    prdata = {31'd0, tickf_q};
                default: prdata = '0;
            endcase
        end
    end

    // Synchronizer and edge flop run continuously regardless of SRC.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
`ifdef RTC_TICK_FILTER_EN
            filt_q  <= 3'd0;
`endif
        end else begin
            sync1_q <= ext_clk_i;
            sync2_q <= sync1_q;
            edge_q  <= lvl;
`ifdef RTC_TICK_FILTER_EN
            filt_q  <= {filt_q[1:0], sync2_q};
`endif
        end
    end

    // Control, prescaler and flag state.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            en_q      <= 1'b0;
            src_q     <= 1'b0;
            tie_q     <= 1'b0;
            div_q     <= '0;
            div_act_q <= '0;
            cnt_q     <= '0;
            rtc_q     <= 1'b0;
            rise_q    <= 1'b0;
            tickf_q   <= 1'b0;
        end else begin
            en_q      <= en_d;
            src_q     <= src_d;
            tie_q     <= tie_d;
            div_q     <= div_d;
            div_act_q <= div_act_d;
            cnt_q     <= cnt_d;
            rtc_q     <= rtc_d;
            rise_q    <= rise_d;
            tickf_q   <= tickf_d;
        end
    end
endmodule

// File: tb/tb_apb4_rtc_tick.sv
// Directed bench for apb4_rtc_tick.
// Ext latency expectations follow RTC_TICK_FILTER_EN.
module tb_apb4_rtc_tick;
    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        ext_clk_i = 1'b0;
    logic        rtc_clk_o, tick_irq_o;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] rv;

`ifdef RTC_TICK_FILTER_EN
    localparam int LAT = 5;
    localparam logic GLITCH_EXP = 1'b0;
`else
    localparam int LAT = 3;
    localparam logic GLITCH_EXP = 1'b1;
`endif

    apb4_rtc_tick #(.RTC_DIV_WIDTH(16)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .ext_clk_i(ext_clk_i), .rtc_clk_o(rtc_clk_o),
        .tick_irq_o(tick_irq_o)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        #1 d = prdata;
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        tick();
        check("rst_rtc", {31'd0, rtc_clk_o}, 0);
        tick();
        presetn = 1'b1;
        tick();
        check("rst_irq", {31'd0, tick_irq_o}, 0);
        check("pready", {31'd0, pready}, 1);
        check("pslverr", {31'd0, pslverr}, 0);
        check("idle_prdata", prdata, 0);
        apb_read(32'h0, rv); check("rst_ctrl", rv, 0);
        apb_read(32'h4, rv); check("rst_div", rv, 0);
        apb_read(32'h8, rv); check("rst_cnt", rv, 0);
        apb_read(32'hC, rv); check("rst_stat", rv, 0);
        apb_write(32'h14, 32'hFFFF_FFFF);
        apb_read(32'h14, rv); check("unmapped_rd", rv, 0);
        apb_read(32'h0, rv); check("unmapped_ctrl", rv, 0);

        // SRC=0 DIV=3: rise 4 cycles after enable, period 8
        apb_write(32'h4, 32'd3);
        apb_write(32'h0, 32'd1);
        check("en_rtc0", {31'd0, rtc_clk_o}, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("div3_rtc_k%0d", k), {31'd0, rtc_clk_o},
                  ((k % 8) >= 4) ? 1 : 0);
        end
        apb_read(32'h8, rv); check("cnt_a", rv, 1);
        apb_read(32'h8, rv); check("cnt_b", rv, 3);
        tick();
        apb_read(32'h8, rv); check("cnt_c", rv, 2);
        apb_read(32'h8, rv); check("cnt_d", rv, 0);
        check("irq_tie0", {31'd0, tick_irq_o}, 0);

        // DIV 3 -> 1 mid half-period
        apb_write(32'h4, 32'd1);
        check("shadow_rtc0", {31'd0, rtc_clk_o}, 0);
        begin
            logic [6:0] exp_w;
            exp_w = 7'b0110011;
            for (int j = 0; j < 7; j++) begin
                tick();
                check($sformatf("shadow_j%0d", j + 1), {31'd0, rtc_clk_o},
                      {31'd0, exp_w[j]});
            end
        end
        apb_read(32'h4, rv); check("div_rd", rv, 1);

        // TIE and W1C behaviour
        apb_write(32'h0, 32'd0);
        tick();
        apb_write(32'hC, 32'd1);
        apb_read(32'hC, rv); check("stat_clr", rv, 0);
        apb_write(32'h4, 32'd1);
        apb_write(32'h0, 32'd5);
        tick(); tick();
        check("tie_rise", {31'd0, rtc_clk_o}, 1);
        check("tie_irq_lag", {31'd0, tick_irq_o}, 0);
        tick();
        check("tie_irq", {31'd0, tick_irq_o}, 1);
        apb_write(32'hC, 32'd1);
        check("w1c_irq", {31'd0, tick_irq_o}, 0);
        check("w1c_rtc", {31'd0, rtc_clk_o}, 0);
        apb_write(32'hC, 32'd1);
        check("setwins_rtc", {31'd0, rtc_clk_o}, 1);
        check("setwins_irq", {31'd0, tick_irq_o}, 1);
        apb_read(32'hC, rv); check("setwins_stat", rv, 1);

        // EN cleared while high, then re-enabled
        apb_write(32'h0, 32'd0);
        tick();
        apb_write(32'h4, 32'd3);
        apb_write(32'h0, 32'd1);
        repeat (5) tick();
        apb_write(32'h0, 32'd0);
        tick();
        check("dis_rtc", {31'd0, rtc_clk_o}, 0);
        apb_read(32'h8, rv); check("dis_cnt", rv, 0);
        apb_read(32'hC, rv); check("dis_tickf", rv, 1);
        apb_write(32'h0, 32'd1);
        repeat (3) tick();
        check("reen_rtc_lo", {31'd0, rtc_clk_o}, 0);
        tick();
        check("reen_rtc_hi", {31'd0, rtc_clk_o}, 1);

        // SRC=1 DIV=0 with a 40-cycle ext clock
        apb_write(32'h0, 32'd0);
        tick();
        apb_write(32'h4, 32'd0);
        apb_write(32'h0, 32'd3);
        check("ext_rtc0", {31'd0, rtc_clk_o}, 0);
        for (int r = 0; r < 2; r++) begin
            ext_clk_i = 1'b1;
            repeat (LAT - 1) tick();
            check($sformatf("ext_pre_r%0d", r), {31'd0, rtc_clk_o}, r);
            tick();
            check($sformatf("ext_tog_r%0d", r), {31'd0, rtc_clk_o}, 1 - r);
            repeat (20 - LAT) tick();
            ext_clk_i = 1'b0;
            repeat (20) tick();
            check($sformatf("ext_fall_r%0d", r), {31'd0, rtc_clk_o}, 1 - r);
        end
        ext_clk_i = 1'b1;
        tick();
        ext_clk_i = 1'b0;
        repeat (10) tick();
        check("ext_glitch", {31'd0, rtc_clk_o}, {31'd0, GLITCH_EXP});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb4_rtc_tick.md
# apb4_rtc_tick

APB4-programmable real-time-clock tick generator that drives the `rtc_clk_i` input of the CLINT timer block, and therefore sets its mtime increment rate. It divides either `pclk` or a synchronized external slow clock by a programmable ratio. It produces a registered, glitch-free square wave `rtc_clk_o`, and it raises a maskable interrupt on every rising edge of that wave.

## Interface
- `RTC_DIV_WIDTH`, default 16: width of the divide register and prescaler counter.
- `apb4.pclk` in 1: system clock; the only clock in the block.
- `apb4.presetn` in 1: reset, asynchronous, active-low.
- `apb4.paddr` in 32: byte address; decoded on `[5:2]`.
- `apb4.psel`, `apb4.penable`, `apb4.pwrite` in 1 each: APB4 control.
- `apb4.pwdata` in 32: write data.
- `apb4.prdata` out 32: read data; reads 0 outside a read access phase.
- `apb4.pready` out 1: tied 1.
- `apb4.pslverr` out 1: tied 0.
- `rtc.ext_clk_i` in 1: asynchronous external slow clock, for example 32.768 kHz.
- `rtc.rtc_clk_o` out 1: divided tick wave, registered on `pclk`; connects to the CLINT `rtc_clk_i`.
- `rtc.tick_irq_o` out 1: tick interrupt, level, equal to STAT.TICKF & CTRL.TIE.

## Operation
- Write handshake: psel & penable & pwrite. Read handshake: psel & penable & ~pwrite.
- Registers, word index `paddr[5:2]`:
  - 0 CTRL, RW: bit0 EN, bit1 SRC (0 = pclk, 1 = ext_clk_i), bit2 TIE.
  - 1 DIV, RW: bits `[RTC_DIV_WIDTH-1:0]`.
  - 2 CNT, RO: current prescaler count.
  - 3 STAT: bit0 TICKF; reads current value; writing 1 clears it.
  - Other indices read 0; writes to them are ignored.
- Source event:
  - SRC=0: every `pclk` cycle.
  - SRC=1: one cycle per synchronized rising edge of `ext_clk_i`. The path is a 2-flop synchronizer followed by an edge-detect flop.
- Prescaler, active only while EN=1, on each source event:
  - If cnt == div_act: cnt ← 0, `rtc_clk_o` toggles, div_act ← DIV.
  - Otherwise: cnt ← cnt + 1.
- `rtc_clk_o` period = 2·(div_act+1) source events, 50% duty.
- DIV is shadowed. A DIV write never shortens or corrupts the current half-period; the new value takes effect after the next terminal count.
- TICKF is set in the cycle `rtc_clk_o` goes 0→1. If the set and a W1C clear happen in the same cycle, set wins.
- EN 1→0: next cycle cnt ← 0, `rtc_clk_o` ← 0, div_act ← DIV. TICKF is retained.
- EN 0→1: counting starts from 0 with div_act = DIV, so the first rising edge of `rtc_clk_o` comes after DIV+1 events.
- SRC changed while EN=1: cnt and `rtc_clk_o` are kept; events come from the new source starting the next cycle. The synchronizer runs continuously, regardless of SRC.
- Counter width is `RTC_DIV_WIDTH`. cnt can never exceed div_act, so it never wraps.

## Timing
- Reset values: CTRL=0, DIV=0, div_act=0, cnt=0, TICKF=0, synchronizer and filter flops=0, `rtc_clk_o`=0, `tick_irq_o`=0, `prdata`=0.
- APB: zero wait states. A write updates its register at the pclk edge that ends the access phase. Reads are combinational within the access phase.
- SRC=0, DIV=N: `rtc_clk_o` toggles every N+1 `pclk` cycles. With DIV=0 it toggles every cycle, giving a period of 2 `pclk`.
- SRC=1: a rising edge on `ext_clk_i` produces a source event 3 `pclk` cycles later (5 cycles with the filter enabled).
- `tick_irq_o` rises 1 cycle after `rtc_clk_o` rises, because TICKF is registered.
- The CLINT then increments mtime once per `rtc_clk_o` period.

## Configuration
- `RTC_TICK_FILTER_EN`:
  - Defined: a 3-sample majority filter sits on the synchronized `ext_clk_i` before edge detection. It adds 2 cycles of latency and rejects pulses shorter than 2 `pclk` cycles.
  - Undefined: no filter; every synchronized rising edge is a source event.
  - The internal `pclk` source path is identical in both builds.

## Test plan
- Reset, then read all four registers → all read 0; `rtc_clk_o`=0 and `tick_irq_o`=0.
- SRC=0, DIV=3, EN=1 → `rtc_clk_o` period of 8 `pclk`, 50% duty. The first rising edge comes 4 cycles after the CTRL write. CNT reads cycle through 0..3.
- DIV changed from 3 to 1 mid-half-period → the current half-period still lasts 4 cycles; after that, half-periods are 2 cycles.
- TIE=1 → `tick_irq_o` asserts one cycle after each `rtc_clk_o` rise. Writing STAT=1 clears it. A clear written in the same cycle as a new rise leaves TICKF=1.
- SRC=1, DIV=0, `ext_clk_i` with a 40-cycle period → `rtc_clk_o` toggles 3 cycles after each ext rise (5 with the filter enabled). With the filter enabled, a 1-cycle glitch on `ext_clk_i` causes no toggle.
- EN cleared while `rtc_clk_o`=1 and cnt=2 → the next cycle shows `rtc_clk_o`=0 and CNT=0. Re-enabling gives a first rise after DIV+1 events.
